wvb_reader: RTL and testbench

WVB_READER -- requirements
Module: wvb_reader

---
 rtl/wvb_reader_if.sv | 32 +++
 rtl/wvb_reader.sv | 180 ++++++++++++++++++
 tb/tb_wvb_reader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wvb_reader_if.sv
// Waveform-buffer reader bus: header FIFO fan-out, buffer read strobes and
// the output stream. The reader drives through "master"; the surrounding
// header FIFO, waveform buffer and stream sink connect through "slave".
interface wvb_reader_if #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 22
);
  // Header FIFO side
  logic                    hdr_empty;
  logic [P_ADR_WIDTH-1:0]  hdr_start_addr;
  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr;
  logic                    hdr_rdreq;
  // Waveform buffer side
  logic                    wvb_rdreq;
  logic                    wvb_rddone;
  logic [P_DATA_WIDTH-1:0] wvb_data;
  // Output stream
  logic [P_DATA_WIDTH-1:0] dout_data;
  logic                    dout_valid;
  logic                    dout_last;
  logic                    dout_ready;

  modport master (
    input  hdr_empty, hdr_start_addr, hdr_stop_addr, wvb_data, dout_ready,
    output hdr_rdreq, wvb_rdreq, wvb_rddone, dout_data, dout_valid, dout_last
  );

  modport slave (
    output hdr_empty, hdr_start_addr, hdr_stop_addr, wvb_data, dout_ready,
    input  hdr_rdreq, wvb_rdreq, wvb_rddone, dout_data, dout_valid, dout_last
  );
endinterface

// File: rtl/wvb_reader.sv
// Waveform-buffer reader: pops one header, streams stop-start+1 samples from
// the waveform buffer through a 4-entry output FIFO, then pulses wvb_rddone.
// Optional feature macro: WVB_RD_HDR_EMIT_EN -- when defined, a header beat
// carrying the sample count precedes the samples of every waveform.
// P_HDR_WAIT must be at least 1; counting the pop cycle, the header wait
// spans P_HDR_WAIT+1 cycles, so the first read lands on cycle T+P_HDR_WAIT+1.
module wvb_reader #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WAIT   = 2,
  parameter int P_RD_LAT     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  wvb_reader_if.master bus
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {IDLE, HDR_POP, HDR_WAIT, READ, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    armed_q;
  logic [7:0]              wait_q, wait_d;
  logic [P_ADR_WIDTH:0]    remaining_q, remaining_d;
  logic [P_RD_LAT-1:0]     vld_pipe_q;
  logic [P_RD_LAT-1:0]     last_pipe_q;

  logic [P_DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q;
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              fifo_cnt_q;

  logic [P_ADR_WIDTH-1:0]  span;
  logic [P_ADR_WIDTH:0]    count_calc;
  logic [7:0]              inflight;
  logic                    wait_last;
  logic                    room;
  logic                    rd_go;
  logic                    push_hdr, push_sample, push, pop;
  logic [P_DATA_WIDTH-1:0] push_data;
  logic                    push_last;

  // Sample count with modular wrap; an all-zero span means the whole buffer.
  assign span       = bus.hdr_stop_addr - bus.hdr_start_addr + P_ADR_WIDTH'(1);
  assign count_calc = (span == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}} : {1'b0, span};

  // Number of buffer reads issued whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < P_RD_LAT; i++) begin
      inflight = inflight + {7'b0, vld_pipe_q[i]};
    end
  end

  assign wait_last = (wait_q == 8'(P_HDR_WAIT - 1));
  // Only credit space that cannot be claimed by reads already in flight.
  assign room      = ({5'b0, fifo_cnt_q} + inflight) < 8'(FIFO_DEPTH);
  assign rd_go     = (state_q == READ) && (remaining_q != '0) && room;

`ifdef WVB_RD_HDR_EMIT_EN
  // The FIFO is empty while the header is being loaded, so the count beat
  // can be written in the capture cycle without contending with samples.
  assign push_hdr = (state_q == HDR_WAIT) && wait_last;
`else
  assign push_hdr = 1'b0;
`endif

  assign push_sample = vld_pipe_q[P_RD_LAT-1];
  assign push        = push_hdr | push_sample;
  assign push_data   = push_hdr ? P_DATA_WIDTH'(count_calc) : bus.wvb_data;
  assign push_last   = !push_hdr && last_pipe_q[P_RD_LAT-1];
  assign pop         = (fifo_cnt_q != '0) && bus.dout_ready;

  // Moore-style strobes; both derive from the state so they can never overlap.
  assign bus.hdr_rdreq  = (state_q == HDR_POP);
  assign bus.wvb_rddone = (state_q == DONE);
  assign bus.wvb_rdreq  = rd_go;

  assign bus.dout_valid = (fifo_cnt_q != '0);
  assign bus.dout_data  = bus.dout_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.dout_last  = bus.dout_valid && fifo_last_q[rd_ptr_q];

  // State, header-wait counter, remaining-sample counter and post-reset arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      wait_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      wait_q      <= wait_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic; armed_q holds the FSM in IDLE for the first clock after reset.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !bus.hdr_empty) state_d = HDR_POP;
      end
      HDR_POP: begin
        wait_d  = '0;
        state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (wait_last) begin
          remaining_d = count_calc;
          state_d     = READ;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      READ: begin
        if (rd_go) remaining_d = remaining_q - (P_ADR_WIDTH+1)'(1);
        if (remaining_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        // The last-flagged beat is the final FIFO entry, so an empty FIFO
        // with nothing in flight means it has been accepted downstream.
        if ((vld_pipe_q == '0) && (fifo_cnt_q == '0)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-latency pipeline: tracks which cycles return data and which one is final.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= rd_go;
      last_pipe_q[0] <= rd_go && (remaining_q == (P_ADR_WIDTH+1)'(1));
      for (int i = 1; i < P_RD_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader: a table of headers is streamed through a
// behavioural header FIFO / waveform buffer; every beat is checked against
// {wave tag, address} and the handshake timing is checked per waveform.
module tb_wvb_reader;
  localparam int AW = 12;
  localparam int DW = 22;
`ifdef WVB_RD_HDR_EMIT_EN
  localparam int EMIT = 1;
`else
  localparam int EMIT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wvb_reader_if #(.P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus ();

  wvb_reader #(
    .P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_HDR_WAIT(2), .P_RD_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural header FIFO and waveform buffer (data = {tag, address}).
  logic [AW-1:0] hq_start [16];
  logic [AW-1:0] hq_stop  [16];
  int            hdr_cnt = 0;
  int            hdr_idx = 0;
  logic [AW-1:0] buf_addr;
  logic [9:0]    buf_tag;
  logic [DW-1:0] stage0, stage1;

  assign bus.hdr_empty = (hdr_idx == hdr_cnt);
  assign bus.wvb_data  = stage1;

  always @(posedge clk) begin
    if (bus.hdr_rdreq) begin
      bus.hdr_start_addr <= hq_start[hdr_idx];
      bus.hdr_stop_addr  <= hq_stop[hdr_idx];
      buf_addr           <= hq_start[hdr_idx];
      buf_tag            <= 10'(hdr_idx);
      hdr_idx            <= hdr_idx + 1;
    end
    if (bus.wvb_rdreq) begin
      stage0   <= {buf_tag, buf_addr};
      buf_addr <= buf_addr + 12'd1;
    end
    stage1 <= stage0;
  end

  typedef struct {
    logic [AW-1:0] start;
    logic [AW-1:0] stop;
    int            exp_n;   // hand-computed sample count
    int            pat;     // 0: ready always, 1: ready 1 of 3, 2: ready 1 of 2
    string         name;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e, output int idx);
    hq_start[hdr_cnt] = s;
    hq_stop[hdr_cnt]  = e;
    idx               = hdr_cnt;
    hdr_cnt           = hdr_cnt + 1;
  endtask

  // Observes one waveform cycle by cycle on the falling edge. stop_after > 0
  // returns right after that many sample beats are accepted (abort test).
  task automatic run_wave(input string name, input logic [AW-1:0] s, input int n,
                          input int pat, input int tag, input int stop_after,
                          output int samples_out, output int mism_out);
    int cyc = 0, n_hdr = 0, t_hdr = -1, t_rd = -1, n_rd = 0, n_done = 0, coinc = 0;
    int beats = 0, samples = 0, mism = 0, last_err = 0, stab_err = 0, max_out = 0;
    int t_first = -1, t_last = -1, outst = 0;
    logic [DW-1:0] hdr_beat, prev_data, exp_d;
    logic prev_last = 1'b0, prev_stall = 1'b0;
    bit done = 1'b0, hit_stop = 1'b0;
    hdr_beat = '0;
    prev_data = '0;
    while (!done && !hit_stop && cyc < 20000) begin
      @(negedge clk);
      case (pat)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = (cyc % 3 == 0);
        default: bus.dout_ready = (cyc % 2 == 0);
      endcase
      if (bus.hdr_rdreq) begin n_hdr++; t_hdr = cyc; end
      if (bus.wvb_rdreq) begin if (t_rd < 0) t_rd = cyc; n_rd++; end
      if (bus.hdr_rdreq && bus.wvb_rddone) coinc++;
      if (bus.wvb_rddone) begin n_done++; done = 1'b1; end
      outst = n_rd - samples;
      if (outst > max_out) max_out = outst;
      if (prev_stall && !(bus.dout_valid && bus.dout_data == prev_data && bus.dout_last == prev_last))
        stab_err++;
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_data  = bus.dout_data;
      prev_last  = bus.dout_last;
      if (bus.dout_valid && bus.dout_ready) begin
        if (beats < EMIT) begin
          hdr_beat = bus.dout_data;
          if (bus.dout_last) last_err++;
        end else begin
          exp_d = {10'(tag), s + 12'(samples)};
          if (bus.dout_data != exp_d) mism++;
          if (bus.dout_last != (samples == n - 1)) last_err++;
          if (t_first < 0) t_first = cyc;
          t_last = cyc;
          samples++;
          if (stop_after != 0 && samples == stop_after) hit_stop = 1'b1;
        end
        beats++;
      end
      cyc++;
    end
    check({name, " timeout"}, (done || hit_stop) ? 0 : 1, 0);
    if (stop_after == 0) begin
      check({name, " hdr_rdreq_pulses"}, n_hdr, 1);
      check({name, " first_rdreq_latency"}, t_rd - t_hdr, 3);
      check({name, " rdreq_count"}, n_rd, n);
      check({name, " sample_beats"}, samples, n);
      check({name, " data_mismatches"}, mism, 0);
      check({name, " last_flag_errors"}, last_err, 0);
      check({name, " rddone_pulses"}, n_done, 1);
      check({name, " hdr_rddone_overlap"}, coinc, 0);
      check({name, " stall_stability_errors"}, stab_err, 0);
      check({name, " outstanding_over_4"}, (max_out > 4) ? 1 : 0, 0);
      if (pat == 0) check({name, " burst_span"}, t_last - t_first, n - 1);
`ifdef WVB_RD_HDR_EMIT_EN
      check({name, " header_beat_data"}, hdr_beat, n);
      check({name, " total_beats"}, beats, n + 1);
`endif
    end
    samples_out = samples;
    mism_out    = mism;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " hdr_rdreq"},  bus.hdr_rdreq,  0);
    check({name, " wvb_rdreq"},  bus.wvb_rdreq,  0);
    check({name, " wvb_rddone"}, bus.wvb_rddone, 0);
    check({name, " dout_valid"}, bus.dout_valid, 0);
    check({name, " dout_last"},  bus.dout_last,  0);
    check({name, " dout_data"},  bus.dout_data,  0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, idx2, samp, mism;
    vecs[0] = '{12'h010, 12'h013,    4, 0, "basic4"};
    vecs[1] = '{12'hFFE, 12'h001,    4, 0, "addr_wrap"};
    vecs[2] = '{12'h000, 12'hFFF, 4096, 0, "full_buffer"};
    vecs[3] = '{12'h100, 12'h10F,   16, 1, "ready_1of3"};
    vecs[4] = '{12'h020, 12'h027,    8, 0, "eight"};
    vecs[5] = '{12'h005, 12'h005,    1, 2, "single"};
    vecs[6] = '{12'h7F0, 12'h7FF,   16, 2, "ready_1of2"};

    bus.dout_ready = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      push_hdr(vecs[i].start, vecs[i].stop, idx);
      run_wave(vecs[i].name, vecs[i].start, vecs[i].exp_n, vecs[i].pat, idx, 0, samp, mism);
      $display("[TB] wave %s start=%03h stop=%03h n=%0d done", vecs[i].name,
               vecs[i].start, vecs[i].stop, vecs[i].exp_n);
    end

    // Abort a 10-sample waveform after 5 accepted beats.
    push_hdr(12'h200, 12'h209, idx);
    run_wave("abort", 12'h200, 10, 0, idx, 5, samp, mism);
    check("abort samples_before_reset", samp, 5);
    check("abort data_mismatches", mism, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort_reset");
    push_hdr(12'h300, 12'h303, idx2);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset idle hdr_rdreq", bus.hdr_rdreq, 0);
    run_wave("after_abort", 12'h300, 4, 0, idx2, 0, samp, mism);
    $display("[TB] abort/recover sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
